// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_if
// Description : Control/status bundle between the test bench / decoder side
//               and the fetch_sequencer program-counter controller.
//               master : drives Start and the decoded control inputs.
//               slave  : the sequencer; drives ProgCtr/ProgSel/status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if #(
    parameter int T = 10
);
    logic         Start;
    logic         Halt;
    logic         BranchAbs;
    logic         BranchRel;
    logic         Call;
    logic         Ret;
    logic         ALU_flag;
    logic [T-1:0] Target;
    logic [T-1:0] ProgCtr;
    logic [1:0]   ProgSel;
    logic         Running;
    logic         Done;
    logic         StackErr;

    modport master (
        output Start, Halt, BranchAbs, BranchRel, Call, Ret, ALU_flag, Target,
        input  ProgCtr, ProgSel, Running, Done, StackErr
    );

    modport slave (
        input  Start, Halt, BranchAbs, BranchRel, Call, Ret, ALU_flag, Target,
        output ProgCtr, ProgSel, Running, Done, StackErr
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Owns the program counter. Runs the Start/Done handshake,
//               steps through programs 1/2/3 and resolves per-cycle PC
//               updates (halt, call/return, absolute/relative branch) with a
//               small LIFO return stack.
// Ports       : Clk   - clock, all state changes on rising edge
//               Reset - synchronous, active-high
//               bus   - fetch_sequencer_if.slave (controls in, PC/status out)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int T        = 10,
    parameter int BASE0    = 0,
    parameter int BASE1    = 256,
    parameter int BASE2    = 512,
    parameter int RS_DEPTH = 4
) (
    input  wire                 Clk,
    input  wire                 Reset,
    fetch_sequencer_if.slave    bus
);
    localparam int c_IW  = $clog2(RS_DEPTH);
    localparam int c_SPW = c_IW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [T-1:0]     r_pc;
    logic [1:0]       r_sel;
    logic             r_running;
    logic             r_done;
    logic             r_err;
    logic [c_SPW-1:0] r_sp;
    logic [T-1:0]     r_stack [RS_DEPTH];

    logic [T-1:0]     w_pc_inc;
    logic [T-1:0]     w_base;
    logic [c_IW-1:0]  w_push_idx;
    logic [c_IW-1:0]  w_top_idx;
    logic             w_empty;
    logic             w_full;

    // PC arithmetic is naturally modulo 2^T; a relative Target is added as a
    // raw T-bit value, which is exactly a signed two's-complement offset.
    assign w_pc_inc   = r_pc + T'(1);
    assign w_empty    = (r_sp == '0);
    assign w_full     = (r_sp == c_SPW'(RS_DEPTH));
    assign w_push_idx = r_sp[c_IW-1:0];
    assign w_top_idx  = c_IW'(r_sp - c_SPW'(1));

    always_comb begin
        w_base = T'(BASE0);
        case (r_sel)
            2'd1:    w_base = T'(BASE1);
            2'd2:    w_base = T'(BASE2);
            default: w_base = T'(BASE0);
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_pc      <= T'(BASE0);
            r_sel     <= 2'd0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_sp      <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.Start) begin
                        r_state <= ARMED;
                        r_pc    <= w_base;
                        r_done  <= 1'b0;
                        r_sp    <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ARMED: begin
                    // PC already sits at the base; releasing Start fetches it.
                    if (!bus.Start) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.Start) begin
                        r_state   <= ARMED;
                        r_pc      <= w_base;
                        r_running <= 1'b0;
                        r_sp      <= '0;
                        r_err     <= 1'b0;
                    end else if (bus.Halt) begin
                        r_state   <= DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                        r_sel     <= (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
                    end else if (bus.Ret) begin
                        if (!w_empty) begin
                            r_pc <= r_stack[w_top_idx];
                            r_sp <= r_sp - c_SPW'(1);
                        end else begin
                            r_pc  <= w_pc_inc;
                            r_err <= 1'b1;
                        end
                    end else if (bus.Call) begin
                        // The jump is taken even when the push is dropped.
                        if (!w_full) begin
                            r_stack[w_push_idx] <= w_pc_inc;
                            r_sp                <= r_sp + c_SPW'(1);
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_pc <= bus.Target;
                    end else if (bus.BranchAbs && bus.ALU_flag) begin
                        r_pc <= bus.Target;
                    end else if (bus.BranchRel && bus.ALU_flag) begin
                        r_pc <= r_pc + bus.Target;
                    end else begin
                        r_pc <= w_pc_inc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ProgCtr  = r_pc;
    assign bus.ProgSel  = r_sel;
    assign bus.Running  = r_running;
    assign bus.Done     = r_done;
    assign bus.StackErr = r_err;
endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;
    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_errors;

    fetch_sequencer_if #(.T(10)) bus ();

    fetch_sequencer #(
        .T(10), .BASE0(0), .BASE1(256), .BASE2(512), .RS_DEPTH(4)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        bus.Start = 0; bus.Halt = 0; bus.BranchAbs = 0; bus.BranchRel = 0;
        bus.Call = 0; bus.Ret = 0; bus.ALU_flag = 0; bus.Target = '0;
    endtask

    task automatic jump(input int tgt);
        clr();
        bus.BranchAbs = 1; bus.ALU_flag = 1; bus.Target = 10'(tgt);
        tick();
        clr();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clr();
        Reset = 1;
        tick(); tick();
        Reset = 0;
        check("rst_pc", int'(bus.ProgCtr), 0);
        check("rst_sel", int'(bus.ProgSel), 0);
        check("rst_run", int'(bus.Running), 0);
        check("rst_done", int'(bus.Done), 0);
        check("rst_err", int'(bus.StackErr), 0);

        // Start held three cycles, then released
        bus.Start = 1;
        tick(); tick(); tick();
        check("armed_pc", int'(bus.ProgCtr), 0);
        check("armed_run", int'(bus.Running), 0);
        bus.Start = 0;
        tick();
        check("run1_pc", int'(bus.ProgCtr), 0);
        check("run1_run", int'(bus.Running), 1);
        tick(); check("run_pc1", int'(bus.ProgCtr), 1);
        tick(); check("run_pc2", int'(bus.ProgCtr), 2);
        tick(); check("run_pc3", int'(bus.ProgCtr), 3);
        check("run_done", int'(bus.Done), 0);
        tick(); tick();
        check("pc5", int'(bus.ProgCtr), 5);

        // Halt at PC=5
        bus.Halt = 1;
        tick();
        clr();
        check("halt_done", int'(bus.Done), 1);
        check("halt_sel", int'(bus.ProgSel), 1);
        check("halt_pc", int'(bus.ProgCtr), 5);
        check("halt_run", int'(bus.Running), 0);
        bus.BranchAbs = 1; bus.ALU_flag = 1; bus.Target = 10'd77;
        tick();
        clr();
        check("done_hold_pc", int'(bus.ProgCtr), 5);
        check("done_hold", int'(bus.Done), 1);

        // Program 2
        bus.Start = 1; tick();
        check("p2_armed_pc", int'(bus.ProgCtr), 256);
        check("p2_done", int'(bus.Done), 0);
        bus.Start = 0; tick();
        check("p2_run_pc", int'(bus.ProgCtr), 256);

        // Branches
        jump(20);
        check("jmp20", int'(bus.ProgCtr), 20);
        bus.BranchAbs = 1; bus.ALU_flag = 0; bus.Target = 10'd100; tick(); clr();
        check("babs_nt", int'(bus.ProgCtr), 21);
        jump(20);
        bus.BranchAbs = 1; bus.ALU_flag = 1; bus.Target = 10'd100; tick(); clr();
        check("babs_t", int'(bus.ProgCtr), 100);
        bus.BranchRel = 1; bus.ALU_flag = 1; bus.Target = 10'h3FB; tick(); clr();
        check("brel_neg", int'(bus.ProgCtr), 95);

        // Call/return nesting
        jump(10);
        bus.Call = 1; bus.Target = 10'd40; tick(); clr();
        check("call1", int'(bus.ProgCtr), 40);
        tick();
        check("call1_next", int'(bus.ProgCtr), 41);
        bus.Call = 1; bus.Target = 10'd60; tick(); clr();
        check("call2", int'(bus.ProgCtr), 60);
        bus.Ret = 1; tick();
        check("ret1", int'(bus.ProgCtr), 42);
        tick(); clr();
        check("ret2", int'(bus.ProgCtr), 11);
        check("cr_err", int'(bus.StackErr), 0);

        // Halt program 2, run program 3
        bus.Halt = 1; tick(); clr();
        check("p2_halt_sel", int'(bus.ProgSel), 2);
        bus.Start = 1; tick(); bus.Start = 0; tick();
        check("p3_pc", int'(bus.ProgCtr), 512);

        // Overflow: five nested calls into 4 entries
        bus.Call = 1; bus.Target = 10'd200;
        tick(); tick(); tick(); tick();
        check("ovf_err0", int'(bus.StackErr), 0);
        tick(); clr();
        check("ovf_pc", int'(bus.ProgCtr), 200);
        check("ovf_err1", int'(bus.StackErr), 1);
        bus.Ret = 1;
        tick(); tick(); tick();
        check("pop3", int'(bus.ProgCtr), 201);
        tick(); clr();
        check("pop4", int'(bus.ProgCtr), 513);

        // Underflow from PC=7
        jump(7);
        bus.Ret = 1; tick(); clr();
        check("unf_pc", int'(bus.ProgCtr), 8);
        check("unf_err", int'(bus.StackErr), 1);

        // Ret beats Call: no push, pop of an empty stack
        bus.Ret = 1; bus.Call = 1; bus.Target = 10'd300; tick(); clr();
        check("retcall_pc", int'(bus.ProgCtr), 9);

        // Halt + Call at PC=30
        bus.Call = 1; bus.Target = 10'd30; tick(); clr();
        bus.Halt = 1; bus.Call = 1; bus.Target = 10'd99; tick(); clr();
        check("hc_pc", int'(bus.ProgCtr), 30);
        check("hc_done", int'(bus.Done), 1);
        check("hc_sel_wrap", int'(bus.ProgSel), 0);
        check("hc_err_sticky", int'(bus.StackErr), 1);
        bus.Start = 1; tick();
        check("start_clr_err", int'(bus.StackErr), 0);
        check("p1_again_pc", int'(bus.ProgCtr), 0);
        bus.Start = 0; tick();

        // PC wrap
        jump(1023);
        check("pc1023", int'(bus.ProgCtr), 1023);
        tick();
        check("pc_wrap", int'(bus.ProgCtr), 0);

        // Into program 2, restart, then reset mid-run
        bus.Halt = 1; tick(); clr();
        bus.Start = 1; tick(); bus.Start = 0; tick(); tick();
        check("p2b_pc", int'(bus.ProgCtr), 257);
        bus.Start = 1; tick();
        check("restart_pc", int'(bus.ProgCtr), 256);
        check("restart_run", int'(bus.Running), 0);
        bus.Start = 0; tick(); tick();
        check("restart_run_pc", int'(bus.ProgCtr), 257);
        Reset = 1; tick(); Reset = 0;
        check("mid_rst_pc", int'(bus.ProgCtr), 0);
        check("mid_rst_sel", int'(bus.ProgSel), 0);
        check("mid_rst_run", int'(bus.Running), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
